// File: rtl/tick_gen.sv
// tick_gen: programmable microsecond tick with a cascaded millisecond tick.
// Latency: tick_us is registered and asserts on the div_cur-th enabled edge of
//          each period; tick_ms asserts together with every MS_DIV-th tick_us.
// Backpressure: none. en gates counting, clr restarts both counters, and a
//          newly loaded divisor only takes effect at a period boundary or while idle.
// Optional: define TICK_GEN_SQW_EN to add the sqw square-wave output.
module tick_gen #(
    parameter int DIV_W    = 16,
    parameter int DIV_INIT = 50,
    parameter int MS_W     = 10,
    parameter int MS_DIV   = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_val,
    output logic             tick_us,
    output logic             tick_ms,
    output logic [DIV_W-1:0] div_cur
`ifdef TICK_GEN_SQW_EN
    ,
    output logic             sqw
`endif
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_INIT);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [MS_W-1:0]  MS_LAST = MS_W'(MS_DIV - 1);
    localparam logic [MS_W-1:0]  MS_ONE  = MS_W'(1);

    logic [DIV_W-1:0] pre_cnt;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] div_clamp;
    logic [MS_W-1:0]  ms_cnt;
    logic             pend_vld;
    logic             wrap;
    logic             apply;

    // Period boundary detect, divisor hand-over point and load clamping.
    // A pending divisor is only swapped in at a wrap or while idle, so the
    // period in flight always completes with the divisor it started with.
    always_comb begin
        wrap      = en && !clr && (pre_cnt == (div_cur - DIV_ONE));
        apply     = pend_vld && !clr && (!en || wrap);
        div_clamp = (div_val < DIV_MIN) ? DIV_MIN : div_val;
    end

    // Prescaler and millisecond cascade counters with their tick strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
            tick_us <= 1'b0;
            tick_ms <= 1'b0;
        end else if (clr) begin
            pre_cnt <= '0;
            ms_cnt  <= '0;
            tick_us <= 1'b0;
            tick_ms <= 1'b0;
        end else if (!en) begin
            tick_us <= 1'b0;
            tick_ms <= 1'b0;
        end else if (wrap) begin
            pre_cnt <= '0;
            tick_us <= 1'b1;
            if (ms_cnt == MS_LAST) begin
                ms_cnt  <= '0;
                tick_ms <= 1'b1;
            end else begin
                ms_cnt  <= ms_cnt + MS_ONE;
                tick_ms <= 1'b0;
            end
        end else begin
            pre_cnt <= pre_cnt + DIV_ONE;
            tick_us <= 1'b0;
            tick_ms <= 1'b0;
        end
    end

    // Divisor staging: a load always lands in div_pend (last one wins) and
    // re-arms pend_vld even on the same edge an older value is applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cur  <= DIV_RST;
            div_pend <= DIV_RST;
            pend_vld <= 1'b0;
        end else begin
            if (apply) begin
                div_cur <= div_pend;
            end
            if (div_load) begin
                div_pend <= div_clamp;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

`ifdef TICK_GEN_SQW_EN
    // Square wave toggles on every edge that raises tick_us.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sqw <= 1'b0;
        end else if (clr) begin
            sqw <= 1'b0;
        end else if (wrap) begin
            sqw <= ~sqw;
        end
    end
`endif

endmodule

// File: tb/tb_tick_gen.sv
// Testbench for tick_gen: directed timeline with literal expectations, then
// randomized en/clr/load/reset traffic checked every cycle against a model
// that counts enabled edges per period and ticks per millisecond window.
module tb_tick_gen;

    localparam int DIV_W    = 16;
    localparam int DIV_INIT = 50;
    localparam int MS_W     = 10;
    localparam int MS_DIV   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             clr = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             tick_us;
    logic             tick_ms;
    logic [DIV_W-1:0] div_cur;
`ifdef TICK_GEN_SQW_EN
    logic             sqw;
`endif

    tick_gen #(
        .DIV_W   (DIV_W),
        .DIV_INIT(DIV_INIT),
        .MS_W    (MS_W),
        .MS_DIV  (MS_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .div_load(div_load),
        .div_val (div_val),
        .tick_us (tick_us),
        .tick_ms (tick_ms),
        .div_cur (div_cur)
`ifdef TICK_GEN_SQW_EN
        ,
        .sqw     (sqw)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: a period is "div enabled edges"; a ms window is
    // "MS_DIV ticks"; a staged divisor is swapped in at a period end or idle edge.
    int m_div, m_pend, m_phase, m_ticks;
    bit m_pv, m_tus, m_tms, m_sqw;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div = DIV_INIT; m_pend = DIV_INIT; m_pv = 0;
            m_phase = 0; m_ticks = 0; m_tus = 0; m_tms = 0; m_sqw = 0;
        end else begin
            if (clr) begin
                m_phase = 0; m_ticks = 0; m_tus = 0; m_tms = 0; m_sqw = 0;
            end else if (!en) begin
                m_tus = 0; m_tms = 0;
                if (m_pv) begin m_div = m_pend; m_pv = 0; end
            end else begin
                m_phase++;
                m_tus = 0; m_tms = 0;
                if (m_phase == m_div) begin
                    m_phase = 0;
                    m_tus = 1;
                    m_sqw = !m_sqw;
                    m_ticks++;
                    if (m_ticks == MS_DIV) begin m_ticks = 0; m_tms = 1; end
                    if (m_pv) begin m_div = m_pend; m_pv = 0; end
                end
            end
            if (div_load) begin
                m_pend = (int'(div_val) < 2) ? 2 : int'(div_val);
                m_pv = 1;
            end
        end
    end

    // Every-cycle comparison of DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("mdl_tick_us", {31'd0, tick_us}, {31'd0, m_tus});
            chk("mdl_tick_ms", {31'd0, tick_ms}, {31'd0, m_tms});
            chk("mdl_div_cur", {16'd0, div_cur}, m_div);
`ifdef TICK_GEN_SQW_EN
            chk("mdl_sqw", {31'd0, sqw}, {31'd0, m_sqw});
`endif
        end
    end

    task automatic load(input int v);
        div_load = 1'b1;
        div_val  = DIV_W'(v);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tick_us", {31'd0, tick_us}, 0);
        chk("rst_tick_ms", {31'd0, tick_ms}, 0);
        chk("rst_div_cur", {16'd0, div_cur}, 50);
        rst = 1'b0;
        en  = 1'b1;
        run_cmp = 1'b1;

        // Directed timeline: e is the number of edges since reset release.
        for (int e = 1; e <= 728; e++) begin
            @(negedge clk);
            case (e)
                49, 51, 99, 309, 331, 376, 392, 398, 426, 487:
                    chk($sformatf("lit_idle_e%0d", e), {31'd0, tick_us}, 0);
                50, 100, 310, 332, 427, 728:
                    chk($sformatf("lit_tick_e%0d", e), {31'd0, tick_us}, 1);
                default: ;
            endcase
            case (e)
                299: chk("lit_div_before_wrap", {16'd0, div_cur}, 50);
                300: begin
                    chk("lit_tick_e300", {31'd0, tick_us}, 1);
                    chk("lit_ms_e300", {31'd0, tick_ms}, 0);
                    chk("lit_div_after_wrap", {16'd0, div_cur}, 10);
                end
                320: chk("lit_ms_e320", {31'd0, tick_ms}, 1);
                330: begin
                    chk("lit_tick_e330", {31'd0, tick_us}, 1);
                    chk("lit_clamp0", {16'd0, div_cur}, 2);
                end
                342: begin
                    chk("lit_tick_e342", {31'd0, tick_us}, 1);
                    chk("lit_div_back50", {16'd0, div_cur}, 50);
                end
                399: begin
                    chk("lit_gap_resume_tick", {31'd0, tick_us}, 1);
                    chk("lit_ms_e399", {31'd0, tick_ms}, 1);
                end
                401: chk("lit_idle_load_pending", {16'd0, div_cur}, 50);
                402: chk("lit_idle_load_applied", {16'd0, div_cur}, 25);
                464: chk("lit_clr_keeps_div", {16'd0, div_cur}, 25);
                488: begin
                    chk("lit_clr_tick", {31'd0, tick_us}, 1);
                    chk("lit_clr_pend_applied", {16'd0, div_cur}, 30);
                end
                668: chk("lit_ms_e668", {31'd0, tick_ms}, 0);
                698: chk("lit_ms_after_clr", {31'd0, tick_ms}, 1);
                default: ;
            endcase
            div_load = 1'b0;
            clr = 1'b0;
            en = !((e >= 372 && e <= 378) || (e >= 399 && e <= 401));
            case (e)
                270: load(10);
                321: load(0);
                333: load(1);
                340: load(50);
                400: load(25);
                462: begin clr = 1'b1; load(30); end
                default: ;
            endcase
        end

        // Asynchronous reset between edges, right after a tick.
        #3 rst = 1'b1;
        #1;
        chk("arst_tick_us", {31'd0, tick_us}, 0);
        chk("arst_tick_ms", {31'd0, tick_ms}, 0);
        chk("arst_div_cur", {16'd0, div_cur}, 50);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic; the model comparison does the checking.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 9) != 0);
            clr      = ($urandom_range(0, 199) == 0);
            div_load = ($urandom_range(0, 29) == 0);
            div_val  = DIV_W'($urandom_range(0, 12));
            if ($urandom_range(0, 999) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Parametrised successor to the fixed 1 us divider.
- Produces single-cycle tick strobes from the system clock:
  - a microsecond tick with a runtime-programmable divisor;
  - a cascaded millisecond tick derived from it.
- Adds enable, synchronous clear and glitch-free divisor reload.
- Feeds the HC-SR04 trigger/echo timers and any other block needing a time base.

Parameters:
- DIV_W, 16: width of the prescaler counter and divisor.
- DIV_INIT, 50: prescaler divisor after reset (50 MHz clk gives 1 us).
- MS_W, 10: width of the cascade counter.
- MS_DIV, 1000: tick_us pulses per tick_ms. Constant, must be 2 or more.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous reset, active-high.
- en, input, 1: count enable. Counters hold while low.
- clr, input, 1: synchronous clear of both counters and both ticks.
- div_load, input, 1: one-cycle strobe that captures div_val as the pending divisor.
- div_val, input, DIV_W: new prescaler divisor.
- tick_us, output, 1: registered strobe, high for exactly one clk cycle per prescaler wrap.
- tick_ms, output, 1: registered strobe, high for one cycle per MS_DIV tick_us pulses.
- div_cur, output, DIV_W: divisor currently in effect.

Behaviour:
- Reset (rst high, asynchronous):
  - pre_cnt = 0, ms_cnt = 0;
  - div_cur = DIV_INIT, div_pend = DIV_INIT, pend_vld = 0;
  - tick_us = 0, tick_ms = 0.
- Priority per clock edge: rst, then clr, then en.
- clr = 1:
  - pre_cnt and ms_cnt go to 0; tick_us and tick_ms go to 0.
  - div_cur, div_pend and pend_vld are unchanged.
  - A div_load in the same cycle is still captured.
- en = 0 (and clr = 0):
  - counters hold; tick_us and tick_ms are 0.
  - If pend_vld is set, div_cur <= div_pend and pend_vld <= 0 (immediate apply while idle).
- Prescaler, with en = 1 and clr = 0:
  - If pre_cnt == div_cur-1: pre_cnt <= 0, tick_us <= 1. Otherwise pre_cnt <= pre_cnt+1, tick_us <= 0.
  - With en held from cycle 1, the first tick_us is high after the div_cur-th enabled edge.
  - Thereafter period = div_cur cycles, duty = 1 cycle.
- Cascade, with en = 1:
  - On a prescaler wrap: if ms_cnt == MS_DIV-1 then ms_cnt <= 0 and tick_ms <= 1, else ms_cnt <= ms_cnt+1.
  - tick_ms = 0 on every other edge.
  - tick_ms is therefore always coincident with a tick_us.
- Divisor load:
  - div_load = 1 sets div_pend <= max(div_val, 2) and pend_vld <= 1.
  - Values 0 and 1 are clamped to 2.
  - A second load before apply overwrites div_pend (last wins).
- Apply while running: on a prescaler wrap edge, if pend_vld then div_cur <= div_pend and pend_vld <= 0.
  - The period in progress always completes with the old divisor; no short or long pulse is emitted.
- Load on wrap edge: a div_load on the same edge as a wrap is captured but not applied until the next wrap (or the next en = 0 cycle).
- Wrap-around: pre_cnt never exceeds div_cur-1. No arithmetic overflow, since div_cur ≤ 2^DIV_W - 1.
- Mid-operation reset: all state returns to reset values immediately; the pending divisor is lost.

Optional Feature:
- Macro: TICK_GEN_SQW_EN.
- Defined:
  - extra output port sqw (1 bit, reset 0), toggling on every edge where tick_us goes high;
  - this gives a 50 % square wave of period 2*div_cur cycles;
  - clr forces sqw to 0; en = 0 holds sqw.
- Undefined: the sqw port and its register do not exist; all other behaviour is identical.

Test Plan:
- Reset release with en = 1, DIV_INIT = 50 -> first tick_us on edge 50, then every 50 cycles, each one cycle wide; tick_ms first on edge 50000.
- Running, div_load with div_val = 10 at pre_cnt = 20 -> current period still ends at 50 cycles; div_cur reads 10 after that wrap; next ticks are 10 cycles apart.
- div_val = 0 and div_val = 1 loads -> div_cur becomes 2; tick_us pulses every 2 cycles (alternating 1/0).
- en dropped for 7 cycles at pre_cnt = 30, then restored -> no ticks during the gap; next tick_us comes 20 enabled cycles after restore. A load during the gap shows on div_cur on the next cycle.
- clr pulse at pre_cnt = 40, ms_cnt = 5 -> both counters read 0 next cycle; next tick_us 50 cycles after clr deasserts; a pending divisor survives.
- rst asserted asynchronously mid-period (between edges) -> outputs 0 and div_cur = 50 immediately, without waiting for clk. With TICK_GEN_SQW_EN defined, sqw toggles at each tick_us (period 100 cycles) and resets to 0.
